// File: rtl/deskew_frame_mover_if.sv
// Signal bundle between the host-side frame mover and its environment:
// input and result AXI-Stream, the shared image BRAM port and the accelerator handshake.
interface deskew_frame_mover_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic             s_axis_tlast;

    logic [WIDTH-1:0] m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tlast;

    logic [12:0]      bram_address;
    logic [WIDTH-1:0] bram_out_data;
    logic [WIDTH-1:0] bram_in_data;
    logic             bram_en;
    logic [3:0]       bram_we;

    logic             dsk_start;
    logic             dsk_ready;
    logic             dsk_done;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready,
        output bram_address, bram_out_data, bram_en, bram_we,
        input  bram_in_data,
        output dsk_start,
        input  dsk_ready, dsk_done
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready,
        input  bram_address, bram_out_data, bram_en, bram_we,
        output bram_in_data,
        input  dsk_start,
        output dsk_ready, dsk_done
    );
endinterface

// File: rtl/deskew_frame_mover.sv
// Host-side frame mover: streams a 28x28 frame into the shared BRAM, kicks the deskew
// accelerator, waits for its interrupt and streams the result back out through a 2-entry skid FIFO.
module deskew_frame_mover #(
    parameter int WIDTH    = 16,
    parameter int ADDRESS  = 4,
    parameter int PIXELS   = 784,
    parameter int OUT_BASE = 784
) (
    input  logic                 clk,
    input  logic                 reset,
    deskew_frame_mover_if.master bus,
    output logic                 busy,
    output logic                 frame_error
);
    typedef enum logic [2:0] {IDLE, LOAD, KICK, WAIT_DONE, DONE_LOW, UNLOAD} state_t;

    localparam logic [9:0]  LAST_IDX  = 10'(PIXELS - 1);
    localparam logic [9:0]  END_IDX   = 10'(PIXELS);
    localparam logic [12:0] STRIDE    = 13'(ADDRESS);
    localparam logic [12:0] OUT_FIRST = 13'(OUT_BASE);

    state_t           state, state_next;
    logic [9:0]       cnt, rd_cnt, out_cnt;
    logic [WIDTH-1:0] fifo_mem [2];
    logic             wr_ptr, rd_ptr, in_flight;
    logic [1:0]       fifo_count;
    logic             start_frame, load_beat, start_unload, issue, pop;
    logic [2:0]       credit;

    assign bus.m_axis_tvalid = (fifo_count != 2'd0);
    assign bus.m_axis_tdata  = bus.m_axis_tvalid ? fifo_mem[rd_ptr] : '0;
    assign bus.m_axis_tlast  = bus.m_axis_tvalid && (out_cnt == LAST_IDX);
    assign pop               = bus.m_axis_tvalid && bus.m_axis_tready;
    assign busy              = (state != IDLE);

    // A word leaving this cycle frees its slot, which keeps reads flowing one per cycle
    // under continuous tready while the skid buffer still can never be overrun.
    assign credit = {1'b0, fifo_count} + {2'b0, in_flight} - {2'b0, pop};

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_next        = state;
        bus.s_axis_tready = 1'b0;
        bus.bram_en       = 1'b0;
        bus.bram_we       = 4'b0000;
        bus.bram_address  = '0;
        bus.bram_out_data = '0;
        bus.dsk_start     = 1'b0;
        start_frame       = 1'b0;
        load_beat         = 1'b0;
        start_unload      = 1'b0;
        issue             = 1'b0;
        case (state)
            IDLE: begin
                if (bus.s_axis_tvalid && bus.dsk_ready) begin
                    start_frame = 1'b1;
                    state_next  = LOAD;
                end
            end
            LOAD: begin
                bus.s_axis_tready = 1'b1;
                if (bus.s_axis_tvalid) begin
                    load_beat         = 1'b1;
                    bus.bram_en       = 1'b1;
                    bus.bram_we       = 4'b0011;
                    bus.bram_address  = 13'(cnt) * STRIDE;
                    bus.bram_out_data = bus.s_axis_tdata;
                    if (cnt == LAST_IDX) begin
                        state_next = KICK;
                    end else if (bus.s_axis_tlast) begin
                        state_next = IDLE;
                    end
                end
            end
            KICK: begin
                if (bus.dsk_ready) begin
                    bus.dsk_start = 1'b1;
                    state_next    = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.dsk_done) state_next = DONE_LOW;
            end
            DONE_LOW: begin
                // Waiting for the interrupt to fall counts a 16-cycle done pulse only once.
                if (!bus.dsk_done && bus.dsk_ready) begin
                    start_unload = 1'b1;
                    state_next   = UNLOAD;
                end
            end
            UNLOAD: begin
                issue = (rd_cnt != END_IDX) && (credit < 3'd2);
                if (issue) begin
                    bus.bram_en      = 1'b1;
                    bus.bram_address = (OUT_FIRST + 13'(rd_cnt)) * STRIDE;
                end
                if (pop && (out_cnt == LAST_IDX)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: flops use non-blocking assignments so each one samples the pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            rd_cnt      <= '0;
            out_cnt     <= '0;
            frame_error <= 1'b0;
            in_flight   <= 1'b0;
            fifo_count  <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
        end else begin
            in_flight <= issue;
            if (start_frame) begin
                frame_error <= 1'b0;
                cnt         <= '0;
            end else if (load_beat) begin
                cnt <= cnt + 10'd1;
                if (bus.s_axis_tlast != (cnt == LAST_IDX)) frame_error <= 1'b1;
            end
            if (start_unload) begin
                rd_cnt     <= '0;
                out_cnt    <= '0;
                fifo_count <= '0;
                wr_ptr     <= 1'b0;
                rd_ptr     <= 1'b0;
            end else begin
                if (issue) rd_cnt <= rd_cnt + 10'd1;
                if (pop) begin
                    out_cnt <= out_cnt + 10'd1;
                    rd_ptr  <= ~rd_ptr;
                end
                if (in_flight) wr_ptr <= ~wr_ptr;
                fifo_count <= fifo_count + {1'b0, in_flight} - {1'b0, pop};
            end
        end
    end

    // NOTE: skid storage has no reset; its output is masked by the occupancy count instead.
    always_ff @(posedge clk) begin
        if (in_flight) fifo_mem[wr_ptr] <= bus.bram_in_data;
    end
endmodule
